scan_digit_ctrl: RTL

SCAN_DIGIT_CTRL -- requirements
Module: scan_digit_ctrl

---
 rtl/scan_digit_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/scan_digit_ctrl.sv
// Four-digit multiplexed display scanner: per-slot guard blanking, frame-aligned value update.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits above slot 0.
module scan_digit_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  nibble,
  output logic        enable,
  output logic [3:0]  digit_sel,
  output logic [1:0]  digit_idx,
  output logic        update_pending,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_W  = CW'(GUARD);

  typedef enum logic {GUARD_PH, SHOW_PH} phase_t;
  localparam phase_t PH_START = (GUARD > 0) ? GUARD_PH : SHOW_PH;

  phase_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [1:0]     idx_nxt;
  logic [15:0]    active, pending;
  logic           rst_blank;
  logic           slot_last, fd, lit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= PH_START;
      cnt            <= '0;
      digit_idx      <= 2'd0;
      active         <= 16'h0000;
      pending        <= 16'h0000;
      update_pending <= 1'b0;
      rst_blank      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_idx <= idx_nxt;
      rst_blank <= 1'b0;
      if (fd) begin
        // Frame boundary: a same-cycle load bypasses the pending register.
        if (load) begin
          active  <= value;
          pending <= value;
        end else if (update_pending) begin
          active  <= pending;
        end
        update_pending <= 1'b0;
      end else if (load) begin
        pending        <= value;
        update_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    slot_last = (cnt == CNT_LAST);
    fd        = slot_last && (digit_idx == 2'd3);
    cnt_nxt   = slot_last ? '0 : cnt + 1'b1;
    idx_nxt   = slot_last ? digit_idx + 2'd1 : digit_idx;
    state_nxt = (cnt_nxt < GUARD_W) ? GUARD_PH : SHOW_PH;
  end

  // Outputs come only from registered state; rst_blank keeps the strobes dark
  // during reset even when GUARD = 0.
  always_comb begin
    nibble     = active[{digit_idx, 2'b00} +: 4];
    lit        = (state == SHOW_PH) && !rst_blank;
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_idx)
      2'd1:    if (active[15:4]  == 12'h000) lit = 1'b0;
      2'd2:    if (active[15:8]  == 8'h00)   lit = 1'b0;
      2'd3:    if (active[15:12] == 4'h0)    lit = 1'b0;
      default: ;
    endcase
`endif
    enable     = lit;
    digit_sel  = lit ? ~(4'b0001 << digit_idx) : 4'b1111;
    frame_done = fd;
  end

endmodule
